// File: rtl/pixel_fetch_if.sv
// ---------------------------------------------------------------------------
// pixel_fetch_if : request, memory-read and pixel handshakes of pixel_fetch
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface pixel_fetch_if #(
    parameter int ADDR_W = 20,
    parameter int SEL_W  = 5,
    parameter int PIX_W  = 8,
    parameter int CNT_W  = 16
);
    localparam int WORD_W = PIX_W * (2 ** SEL_W);

    logic              in_req_valid;
    logic              out_req_ready;
    logic [ADDR_W-1:0] in_req;
    logic [SEL_W-1:0]  in_sel;
    logic              out_mem_rd;
    logic [ADDR_W-1:0] out_mem_addr;
    logic              in_mem_valid;
    logic [WORD_W-1:0] in_mem_data;
    logic              out_pix_valid;
    logic              in_pix_ready;
    logic [PIX_W-1:0]  out_pixel;
    logic              in_flush;
    logic [CNT_W-1:0]  out_miss_cnt;

    modport master (
        output in_req_valid, in_req, in_sel, in_mem_valid, in_mem_data,
               in_pix_ready, in_flush,
        input  out_req_ready, out_mem_rd, out_mem_addr, out_pix_valid,
               out_pixel, out_miss_cnt
    );

    modport slave (
        input  in_req_valid, in_req, in_sel, in_mem_valid, in_mem_data,
               in_pix_ready, in_flush,
        output out_req_ready, out_mem_rd, out_mem_addr, out_pix_valid,
               out_pixel, out_miss_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pixel_fetch.sv
// ---------------------------------------------------------------------------
// pixel_fetch : one-word cached 256-bit fetch with 8-bit pixel extraction
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pixel_fetch #(
    parameter int ADDR_W = 20,
    parameter int SEL_W  = 5,
    parameter int PIX_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pixel_fetch_if.slave  bus
);
    localparam int WORD_W = PIX_W * (2 ** SEL_W);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        OUT      = 2'd2
    } state_t;

    state_t            state;
    logic              cache_valid;
    logic [ADDR_W-1:0] cache_tag;
    logic [WORD_W-1:0] cache_word;
    logic [ADDR_W-1:0] pend_addr;
    logic [SEL_W-1:0]  pend_sel;
    logic              flushed;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              pix_valid;
    logic [PIX_W-1:0]  pixel;
    logic [CNT_W-1:0]  miss_cnt;

    logic req_ready;
    logic accept;
    logic hit;

    function automatic logic [PIX_W-1:0] pick(input logic [WORD_W-1:0] w,
                                              input logic [SEL_W-1:0]  s);
        return w[int'(s)*PIX_W +: PIX_W];
    endfunction

    // Ready is forced low during reset even though the state already reads IDLE.
    assign req_ready = rst_n & ((state == IDLE) | ((state == OUT) & bus.in_pix_ready));
    assign accept    = bus.in_req_valid & req_ready;
    assign hit       = cache_valid & (cache_tag == bus.in_req) & ~bus.in_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_word  <= '0;
            pend_addr   <= '0;
            pend_sel    <= '0;
            flushed     <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            pix_valid   <= 1'b0;
            pixel       <= '0;
            miss_cnt    <= '0;
        end else begin
            mem_rd <= 1'b0;
            if (bus.in_flush) begin
                cache_valid <= 1'b0;
                miss_cnt    <= '0;
            end
            unique case (state)
                IDLE, OUT: begin
                    if (accept) begin
                        pend_addr <= bus.in_req;
                        pend_sel  <= bus.in_sel;
                        if (hit) begin
                            state     <= OUT;
                            pixel     <= pick(cache_word, bus.in_sel);
                            pix_valid <= 1'b1;
                        end else begin
                            state     <= MEM_WAIT;
                            pix_valid <= 1'b0;
                            mem_rd    <= 1'b1;
                            mem_addr  <= bus.in_req;
                            flushed   <= 1'b0;
                            if (!bus.in_flush && (miss_cnt != '1))
                                miss_cnt <= miss_cnt + CNT_W'(1);
                        end
                    end else if ((state == OUT) && bus.in_pix_ready) begin
                        state     <= IDLE;
                        pix_valid <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (bus.in_flush)
                        flushed <= 1'b1;
                    // A flush seen while waiting still delivers the pixel but leaves the line invalid.
                    if (bus.in_mem_valid) begin
                        cache_word  <= bus.in_mem_data;
                        cache_tag   <= pend_addr;
                        cache_valid <= ~(flushed | bus.in_flush);
                        pixel       <= pick(bus.in_mem_data, pend_sel);
                        pix_valid   <= 1'b1;
                        state       <= OUT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_req_ready = req_ready;
    assign bus.out_mem_rd    = mem_rd;
    assign bus.out_mem_addr  = mem_addr;
    assign bus.out_pix_valid = pix_valid;
    assign bus.out_pixel     = pixel;
    assign bus.out_miss_cnt  = miss_cnt;

endmodule

`default_nettype wire

// File: doc/pixel_fetch.md
Name: pixel_fetch

Overview:
- Sits directly downstream of the pixel address decoder.
- Accepts a decoded (word address, byte select) request and fetches the 256-bit word from feature/filter memory over a read handshake.
- Extracts the selected 8-bit pixel and returns it to the systolic array feeder.
- Holds a one-entry word cache, so consecutive pixels in the same 32-pixel word need no new memory read.

Parameters:
- ADDR_W, 20, request/memory word address width.
- SEL_W, 5, byte select width; pixels per word = 2**SEL_W.
- PIX_W, 8, pixel width; WORD_W = PIX_W*2**SEL_W = 256.
- CNT_W, 16, miss counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_req_valid  in  1  request valid from decoder stage
- out_req_ready  out  1  fetcher accepts request this cycle
- in_req  in  ADDR_W  decoded word address
- in_sel  in  SEL_W  decoded byte select (byte 31 = leftmost pixel)
- out_mem_rd  out  1  memory read strobe, single-cycle pulse
- out_mem_addr  out  ADDR_W  memory read address, valid with out_mem_rd
- in_mem_valid  in  1  read data return strobe
- in_mem_data  in  WORD_W  returned word
- out_pix_valid  out  1  pixel valid to consumer
- in_pix_ready  in  1  consumer accepts pixel
- out_pixel  out  PIX_W  fetched pixel
- in_flush  in  1  invalidate cached word and clear miss counter
- out_miss_cnt  out  CNT_W  saturating count of memory reads issued

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; cache valid=0; tag=0; word=0.
  - out_mem_rd=0, out_mem_addr=0, out_pix_valid=0, out_pixel=0, out_miss_cnt=0, out_req_ready=0 while in reset.
  - Reset mid-read abandons the read; an in_mem_valid arriving later in IDLE is ignored.
- States:
  - IDLE: out_req_ready=1.
  - MEM_WAIT: out_req_ready=0.
  - OUT: out_req_ready=in_pix_ready.
- Accept = in_req_valid & out_req_ready; latch in_req/in_sel into pending registers.
- Hit (cache valid & tag==in_req at accept):
  - Next cycle enter OUT with out_pixel=word[in_sel*PIX_W +: PIX_W] and out_pix_valid=1.
  - Latency 1 cycle.
- Miss:
  - Next cycle out_mem_rd=1 for exactly one cycle, out_mem_addr=in_req; state MEM_WAIT.
  - out_miss_cnt increments, saturating at all-ones.
- MEM_WAIT:
  - Wait for in_mem_valid, with no timeout.
  - On in_mem_valid: word<=in_mem_data, tag<=pending addr, valid<=1.
  - Next cycle OUT with the pixel extracted from the returned word.
  - in_mem_valid may arrive the cycle after out_mem_rd (minimum miss latency 3 cycles, accept to out_pix_valid).
- OUT:
  - out_pixel/out_pix_valid held stable until in_pix_ready=1.
  - On in_pix_ready with no new accept: IDLE.
  - On in_pix_ready with simultaneous accept: a hit stays in OUT with the new pixel next cycle (1 pixel/clk streaming); a miss goes to memory read as above, with out_pix_valid=0 next cycle.
- in_mem_valid outside MEM_WAIT: ignored.
- in_flush:
  - Clears cache valid and out_miss_cnt next cycle.
  - A request accepted in the same cycle as flush is treated as a miss.
  - Flush during MEM_WAIT: the returned word is still used for the pending pixel but is not cached (valid stays 0).
  - Flush has priority over the counter increment in the same cycle.
- Extraction uses pure byte indexing; in_sel=31 selects bits 255:248 and in_sel=0 selects bits 7:0.

Test Plan:
- Cold miss: reset, req addr=0x00010 sel=31, memory returns word with bits[255:248]=0xA5 two cycles after strobe -> one out_mem_rd pulse with addr 0x00010, out_pixel=0xA5, out_miss_cnt=1.
- Streaming hits: after cold miss, sel=30..0 back-to-back with in_pix_ready=1 -> no out_mem_rd, 31 pixels on consecutive cycles matching word bytes, out_miss_cnt stays 1.
- Backpressure: hold in_pix_ready=0 for 5 cycles in OUT -> out_pixel stable, out_req_ready=0, no request lost; release -> next request accepted that cycle.
- Address change: hit at 0x00010, then req 0x00011 -> new read issued, cache retagged to 0x00011, out_miss_cnt=2.
- Flush mid-read: assert in_flush in MEM_WAIT -> pending pixel delivered correctly; repeated request to same addr issues a new read; out_miss_cnt=1 (counter cleared by flush, then the new read counted).
- Reset mid-read: rst_n low during MEM_WAIT, stray in_mem_valid after release -> all outputs 0, state IDLE, stray data ignored; counter saturation: force 65536 misses -> out_miss_cnt=0xFFFF.
